// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: one datapath step per state, stalls on mem_ready.
// Outputs decode from the state register, plus the opcode latched in DECODE.
module multicycle_control_fsm #(
  parameter logic [5:0] JR_FUNCT  = 6'b001000,
  parameter bit         RA_SEL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwrite_cond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdest,
  output logic       memtoreg,
  output logic       ra_sel,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic [1:0] load_control,
  output logic [1:0] store_control,
  output logic       extend,
  output logic       lui_control,
  output logic       illegal,
  output logic [3:0] state
);
  // state  | meaning
  // FETCH  | read instruction at PC, PC+4 -> PC on mem_ready
  // DECODE | branch target -> ALUOut, dispatch on opcode
  // MEMADR | base + imm -> ALUOut
  // MEMRD  | load access, wait for mem_ready
  // MEMWB  | MDR -> rt
  // MEMWR  | store access, wait for mem_ready
  // EXEC   | R-type ALU op
  // RWB    | ALUOut -> rd
  // BRANCH | compare A,B; PC <= ALUOut if zero
  // JUMP   | PC <= jump target
  // JAL    | PC <= jump target, PC -> $31
  // JR     | PC <= A
  // IEXEC  | A + imm (addi/lui)
  // IWB    | ALUOut or imm<<16 -> rt
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    JAL = 4'd10, JR = 4'd11, IEXEC = 4'd12, IWB = 4'd13
  } state_t;

  state_t     state_q;
  state_t     decode_next;
  logic [5:0] op_q;
  logic [1:0] size_code;

  always_comb begin
    decode_next = FETCH;
    case (opcode)
      6'b100011, 6'b100000, 6'b100001, 6'b100100,
      6'b100101, 6'b101011, 6'b101000, 6'b101001: decode_next = MEMADR;
      6'b000000: decode_next = (funct == JR_FUNCT) ? JR : EXEC;
      6'b000100: decode_next = BRANCH;
      6'b000010: decode_next = JUMP;
      6'b000011: decode_next = JAL;
      6'b001000, 6'b001111: decode_next = IEXEC;
      default: decode_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      case (state_q)
        FETCH:  if (mem_ready) state_q <= DECODE;
        DECODE: begin
          op_q    <= opcode;
          state_q <= decode_next;
        end
        // stores are 101xxx, loads 100xxx
        MEMADR: state_q <= op_q[3] ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) state_q <= MEMWB;
        MEMWR:  if (mem_ready) state_q <= FETCH;
        EXEC:   state_q <= RWB;
        IEXEC:  state_q <= IWB;
        default: state_q <= FETCH;
      endcase
    end
  end

  // word = xx11, byte = xx00, half = xx01 across the load/store opcodes
  always_comb begin
    case (op_q[1:0])
      2'b00:   size_code = 2'b01;
      2'b01:   size_code = 2'b10;
      default: size_code = 2'b00;
    endcase
  end

  always_comb begin
    pcwrite = 1'b0; pcwrite_cond = 1'b0; iord = 1'b0; memread = 1'b0;
    memwrite = 1'b0; irwrite = 1'b0; regwrite = 1'b0; regdest = 1'b0;
    memtoreg = 1'b0; ra_sel = 1'b0; alusrca = 1'b0; alusrcb = 2'b00;
    aluop = 2'b00; pcsource = 2'b00; load_control = 2'b00; store_control = 2'b00;
    extend = 1'b0; lui_control = 1'b0; illegal = 1'b0;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // reset gating keeps the reset cycle free of IR/PC loads
        irwrite = mem_ready & ~reset;
        pcwrite = mem_ready & ~reset;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = (decode_next == FETCH);
      end
      MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:  begin iord = 1'b1; memread = 1'b1; end
      MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; end
      MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
      EXEC:   begin alusrca = 1'b1; aluop = 2'b10; end
      RWB:    begin regwrite = 1'b1; regdest = 1'b1; end
      BRANCH: begin alusrca = 1'b1; aluop = 2'b01; pcwrite_cond = 1'b1; pcsource = 2'b01; end
      JUMP:   begin pcwrite = 1'b1; pcsource = 2'b10; end
      JAL:    begin pcwrite = 1'b1; pcsource = 2'b10; regwrite = 1'b1; ra_sel = RA_SEL_EN; end
      JR:     begin pcwrite = 1'b1; pcsource = 2'b11; end
      IEXEC:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      IWB:    begin regwrite = 1'b1; lui_control = (op_q == 6'b001111); end
      default: ;
    endcase
    if (state_q inside {MEMADR, MEMRD, MEMWB, MEMWR}) begin
      if (op_q[3]) store_control = size_code;
      else begin
        load_control = size_code;
        extend       = ~op_q[2] & ~op_q[1];
      end
    end
  end

  assign state = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: vector table, reset corner cases and random instruction stream
// checked every cycle against an instruction-level model.
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pcwrite, pcwrite_cond, iord, memread, memwrite, irwrite, regwrite;
  logic       regdest, memtoreg, ra_sel, alusrca, extend, lui_control, illegal;
  logic [1:0] alusrcb, aluop, pcsource, load_control, store_control;
  logic [3:0] state;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwrite_cond(pcwrite_cond),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .regdest(regdest), .memtoreg(memtoreg), .ra_sel(ra_sel),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
    .load_control(load_control), .store_control(store_control), .extend(extend),
    .lui_control(lui_control), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcwrite, pcwrite_cond, iord, memread, memwrite, irwrite, regwrite;
    logic regdest, memtoreg, ra_sel, alusrca;
    logic [1:0] alusrcb, aluop, pcsource, load_control, store_control;
    logic extend, lui_control, illegal;
    logic [3:0] state;
  } ctl_t;

  ctl_t got;
  assign got = {pcwrite, pcwrite_cond, iord, memread, memwrite, irwrite, regwrite,
                regdest, memtoreg, ra_sel, alusrca, alusrcb, aluop, pcsource,
                load_control, store_control, extend, lui_control, illegal, state};

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] OP_LW = 6'b100011, OP_LB = 6'b100000, OP_LH = 6'b100001,
    OP_LBU = 6'b100100, OP_LHU = 6'b100101, OP_SW = 6'b101011, OP_SB = 6'b101000,
    OP_SH = 6'b101001, OP_R = 6'b000000, OP_BEQ = 6'b000100, OP_J = 6'b000010,
    OP_JAL = 6'b000011, OP_ADDI = 6'b001000, OP_LUI = 6'b001111;

  function automatic bit is_load(logic [5:0] op);
    return op inside {OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU};
  endfunction
  function automatic bit is_store(logic [5:0] op);
    return op inside {OP_SW, OP_SB, OP_SH};
  endfunction
  function automatic bit is_known(logic [5:0] op);
    return is_load(op) || is_store(op) ||
           op inside {OP_R, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_LUI};
  endfunction

  // Expected control word for a spec state number, written from the per-state rules.
  function automatic ctl_t exp_out(int s, logic [5:0] op, logic mr, logic rst);
    ctl_t e;
    logic [1:0] sz;
    e = '0;
    e.state = s[3:0];
    sz = (op inside {OP_LB, OP_LBU, OP_SB}) ? 2'd1 :
         (op inside {OP_LH, OP_LHU, OP_SH}) ? 2'd2 : 2'd0;
    case (s)
      0:  begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr & ~rst; e.pcwrite = mr & ~rst; end
      1:  begin e.alusrcb = 2'b11; e.illegal = !is_known(op); end
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  begin e.iord = 1; e.memread = 1; end
      4:  begin e.regwrite = 1; e.memtoreg = 1; end
      5:  begin e.iord = 1; e.memwrite = 1; end
      6:  begin e.alusrca = 1; e.aluop = 2'b10; end
      7:  begin e.regwrite = 1; e.regdest = 1; end
      8:  begin e.alusrca = 1; e.aluop = 2'b01; e.pcwrite_cond = 1; e.pcsource = 2'b01; end
      9:  begin e.pcwrite = 1; e.pcsource = 2'b10; end
      10: begin e.pcwrite = 1; e.pcsource = 2'b10; e.regwrite = 1; e.ra_sel = 1; end
      11: begin e.pcwrite = 1; e.pcsource = 2'b11; end
      12: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      13: begin e.regwrite = 1; e.lui_control = (op == OP_LUI); end
      default: ;
    endcase
    if (s >= 2 && s <= 5) begin
      if (is_load(op)) begin
        e.load_control = sz;
        e.extend = op inside {OP_LB, OP_LH};
      end
      if (is_store(op)) e.store_control = sz;
    end
    return e;
  endfunction

  task automatic check(input string nm, input ctl_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", nm, got, got.state, exp, exp.state);
    end
  endtask

  // One cycle: drive inputs at negedge, check outputs, state advances at the next posedge.
  task automatic step(input int s, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic rst, input string nm);
    @(negedge clk);
    reset = rst; opcode = op; funct = fn; mem_ready = mr; zero = 1'($urandom);
    #1;
    check(nm, exp_out(s, op, mr, rst));
  endtask

  // Runs one instruction from FETCH; the path is the instruction's state walk without stalls.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fetch_st,
                           input int mem_st, input string nm, output int cycles);
    int path[$];
    path = {0, 1};
    if (is_load(op))       path = {path, 2, 3, 4};
    else if (is_store(op)) path = {path, 2, 5};
    else if (op == OP_R)   path = (fn == 6'b001000) ? {path, 11} : {path, 6, 7};
    else if (op == OP_BEQ) path.push_back(8);
    else if (op == OP_J)   path.push_back(9);
    else if (op == OP_JAL) path.push_back(10);
    else if (op inside {OP_ADDI, OP_LUI}) path = {path, 12, 13};
    cycles = 0;
    foreach (path[i]) begin
      int s = path[i];
      int stalls = (s == 0) ? fetch_st : (s == 3 || s == 5) ? mem_st : 0;
      for (int k = 0; k <= stalls; k++) begin
        logic mr = (k == stalls) ? 1'b1 : 1'b0;
        if (!(s inside {0, 3, 5})) mr = 1'($urandom);
        if (s == 0) step(s, 6'($urandom), 6'($urandom), mr, 1'b0, nm);
        else        step(s, op, fn, mr, 1'b0, nm);
        cycles++;
      end
    end
  endtask

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    int         fetch_st;
    int         mem_st;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   lat;

  initial begin
    vecs = '{
      '{"lw",        OP_LW,   6'h00, 0, 0, 5},
      '{"sh_stall",  OP_SH,   6'h00, 0, 3, 7},
      '{"lbu",       OP_LBU,  6'h00, 0, 0, 5},
      '{"lb",        OP_LB,   6'h00, 1, 0, 6},
      '{"beq",       OP_BEQ,  6'h00, 0, 0, 3},
      '{"beq2",      OP_BEQ,  6'h15, 0, 0, 3},
      '{"jr",        OP_R,    6'b001000, 0, 0, 3},
      '{"add",       OP_R,    6'b100000, 0, 0, 4},
      '{"illegal",   6'b111111, 6'h00, 0, 0, 2},
      '{"sw",        OP_SW,   6'h00, 0, 2, 6},
      '{"lhu",       OP_LHU,  6'h00, 2, 1, 8},
      '{"lh",        OP_LH,   6'h00, 0, 0, 5},
      '{"sb",        OP_SB,   6'h00, 0, 0, 4},
      '{"addi",      OP_ADDI, 6'h00, 0, 0, 4},
      '{"lui",       OP_LUI,  6'h00, 0, 0, 4},
      '{"j",         OP_J,    6'h00, 0, 0, 3},
      '{"jal",       OP_JAL,  6'h00, 0, 0, 3}
    };

    // two reset cycles with mem_ready high: no IR/PC load may slip through
    @(posedge clk);
    step(0, OP_LW, 6'h00, 1'b1, 1'b1, "reset0");
    step(0, OP_LW, 6'h00, 1'b1, 1'b1, "reset1");

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].fetch_st, vecs[i].mem_st, vecs[i].nm, lat);
      n_cmp++;
      if (lat != vecs[i].exp_lat) begin
        n_err++;
        $display("FAIL latency_%s: got %0d expected %0d", vecs[i].nm, lat, vecs[i].exp_lat);
      end
    end

    // reset while stalled in MEMRD abandons the load
    step(0, OP_LW, 6'h00, 1'b1, 1'b0, "rst_mid_fetch");
    step(1, OP_LW, 6'h00, 1'b1, 1'b0, "rst_mid_decode");
    step(2, OP_LW, 6'h00, 1'b1, 1'b0, "rst_mid_memadr");
    step(3, OP_LW, 6'h00, 1'b0, 1'b0, "rst_mid_memrd");
    step(3, OP_LW, 6'h00, 1'b1, 1'b1, "rst_mid_assert");
    step(0, OP_LW, 6'h00, 1'b1, 1'b1, "rst_mid_after");
    step(0, OP_LW, 6'h00, 1'b0, 1'b0, "rst_mid_release");

    // a jr funct under a non-R opcode must not divert to JR
    run_instr(OP_ADDI, 6'b001000, 0, 0, "addi_jrfunct", lat);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      logic [5:0] legal[14];
      legal = '{OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU, OP_SW, OP_SB, OP_SH,
                OP_R, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_LUI};
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), "random", lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
